// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources,
// with bounded bursts per grant and a watchdog on every frame's tx_done.
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 send,
  output logic [7:0]           data_in,
  input  logic                 tx_done,
  input  logic                 tx_active,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [3:0]       BURST_MAX = 4'(MAX_BURST);
  localparam logic [19:0]      WD_LAST   = 20'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] pick_idx, scan_idx, grant_next;
  logic             pick_found;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [19:0]      wd_cnt_q, wd_cnt_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [7:0]       req_byte [NUM_REQ];
  logic             tx_active_unused;

  // tx_active is status only; sequencing relies solely on tx_done.
  assign tx_active_unused = tx_active;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_byte
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Scan from the farthest offset back to rr_ptr so the closest valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign grant_next = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    data_in_d   = data_in_q;
    req_ready   = '0;
    send        = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          data_in_d           = req_byte[pick_idx];
          grant_d             = pick_idx;
          burst_cnt_d         = 4'd1;
          state_d             = SEND;
        end
      end
      SEND: begin
        send     = 1'b1;
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 20'd1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          if (req_valid[grant_q] && (burst_cnt_q < BURST_MAX)) begin
            req_ready[grant_q] = 1'b1;
            data_in_d          = req_byte[grant_q];
            burst_cnt_d        = burst_cnt_q + 4'd1;
            state_d            = SEND;
          end else begin
            rr_ptr_d = grant_next;
            state_d  = IDLE;
          end
        end else if (wd_cnt_q >= WD_LAST) begin
          timeout_err = 1'b1;
          rr_ptr_d    = grant_next;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      wd_cnt_q    <= '0;
      data_in_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      data_in_q   <= data_in_d;
    end
  end

  assign data_in  = data_in_q;
  assign grant_id = 3'(grant_q);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: arbitration vector table plus a grant/byte
// scoreboard fed by byte-source models and a UART responder with programmable tx_done delay.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 send;
  logic [7:0]           data_in;
  logic                 tx_done;
  logic                 tx_active;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  uart_tx_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .send       (send),
    .data_in    (data_in),
    .tx_done    (tx_done),
    .tx_active  (tx_active),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         pre;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         exp_id;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         send_cyc_q[$];
  vec_t       vecs [10];
  int         burst_gaps [5] = '{5, 5, 5, 6, 5};

  logic [7:0] src_bytes [NUM_REQ][8];
  int         src_len [NUM_REQ];
  int         src_idx [NUM_REQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int send_cnt = 0;
  int ready_cnt = 0;
  int to_cnt = 0;
  int last_send_cyc = 0;
  int last_ready_cyc = 0;
  int last_to_cyc = 0;
  int done_delay = 3;
  bit resp_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] data_of(input int id, input int n);
    return 8'(32 * id + n);
  endfunction

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 3'(id);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic load_src(input int id, input int n, input logic [7:0] base);
    src_idx[id] = 0;
    src_len[id] = n;
    for (int k = 0; k < n; k++) src_bytes[id][k] = 8'(base + 8'(k));
  endtask

  // Byte sources: present the current byte until the DUT accepts it.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = (src_idx[i] < src_len[i]);
        if (src_idx[i] < src_len[i]) req_data[8*i +: 8] = src_bytes[i][src_idx[i]];
        else req_data[8*i +: 8] = 8'h00;
      end
    end
  end

  // UART model: pulses tx_done done_delay cycles after each send (never if done_delay <= 0).
  initial begin
    tx_done   = 1'b0;
    tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (send && done_delay > 0) begin
        resp_busy = 1'b1;
        tx_active = 1'b1;
        repeat (done_delay) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done   = 1'b0;
        tx_active = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: handshake legality, send latency and the grant/byte scoreboard.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      checkOutput("ready_onehot_valid",
                  32'(((req_ready & (req_ready - 1'b1)) == '0) && ((req_ready & ~req_valid) == '0)), 1);
      ready_cnt++;
      last_ready_cyc = cyc;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) src_idx[i]++;
    end
    if (send) begin
      send_cnt++;
      checkOutput("send_after_ready", cyc - last_ready_cyc, 1);
      checkOutput("send_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("send_grant_id", grant_id, mon_e.id);
        checkOutput("send_data_in", data_in, mon_e.data);
      end
      send_cyc_q.push_back(cyc);
      last_send_cyc = cyc;
    end
    if (timeout_err) begin
      to_cnt++;
      last_to_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    exp_q.delete();
    send_cyc_q.delete();
    @(negedge clk);
    #1;
    checkOutput("reset_state", {req_ready, send, data_in, grant_id, busy, timeout_err}, '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !resp_busy && req_valid == '0) break;
    end
    checkOutput(name, 32'(k < budget), 1);
  endtask

  task automatic wait_send(input string name, input int base, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (send_cnt > base) break;
    end
    checkOutput(name, 32'(k < budget), 1);
  endtask

  // One arbitration vector: optionally service `pre` to move rr_ptr, then offer `valid`.
  task automatic applyStimulus(input vec_t v, input int n);
    do_reset();
    if (v.pre >= 0) begin
      push_exp(v.pre, 8'(8'hC0 + n));
      @(posedge clk);
      #1 load_src(v.pre, 1, 8'(8'hC0 + n));
      wait_quiet("vec_pre_done", 200);
    end
    if (v.exp_id >= 0) push_exp(v.exp_id, data_of(v.exp_id, n));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (v.valid[i]) load_src(i, 1, data_of(i, n));
    @(negedge clk);
    #1;
    checkOutput("vec_ready", req_ready, v.exp_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) src_len[i] = 0;
    wait_quiet("vec_done", 200);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int  base_send;
    int  base_ready;
    int  base_to;
    int  busy_len;
    bit  found;

    reset_n = 1'b0;
    vecs[0] = '{-1, 4'b0001, 4'b0001, 0};
    vecs[1] = '{-1, 4'b0110, 4'b0010, 1};
    vecs[2] = '{-1, 4'b1000, 4'b1000, 3};
    vecs[3] = '{-1, 4'b0000, 4'b0000, -1};
    vecs[4] = '{-1, 4'b1111, 4'b0001, 0};
    vecs[5] = '{ 1, 4'b0011, 4'b0001, 0};
    vecs[6] = '{ 1, 4'b1110, 4'b0100, 2};
    vecs[7] = '{ 3, 4'b1010, 4'b0010, 1};
    vecs[8] = '{ 2, 4'b0111, 4'b0001, 0};
    vecs[9] = '{ 0, 4'b1001, 4'b1000, 3};

    done_delay = 3;
    for (int v = 0; v < 10; v++) applyStimulus(vecs[v], v);

    // Single byte: send one cycle after ready, busy and data held until tx_done.
    do_reset();
    done_delay = 10;
    base_ready = ready_cnt;
    base_send  = send_cnt;
    push_exp(0, 8'hA5);
    @(posedge clk);
    #1 load_src(0, 1, 8'hA5);
    wait_send("t1_send_seen", base_send, 20);
    busy_len = 0;
    for (int k = 0; k < 50; k++) begin
      if (!busy) break;
      busy_len++;
      checkOutput("t1_data_hold", data_in, 8'hA5);
      @(negedge clk);
      #1;
    end
    checkOutput("t1_busy_cycles", busy_len, 11);
    checkOutput("t1_data_after", data_in, 8'hA5);
    checkOutput("t1_ready_count", ready_cnt - base_ready, 1);
    wait_quiet("t1_quiet", 50);

    // Rotation with bursts: 0 x4, 1 x2, 2 x2, 3 x2, then wrap to 0.
    do_reset();
    done_delay = 2;
    for (int k = 0; k < 4; k++) push_exp(0, 8'(8'h00 + k));
    for (int k = 0; k < 2; k++) push_exp(1, 8'(8'h10 + k));
    for (int k = 0; k < 2; k++) push_exp(2, 8'(8'h20 + k));
    for (int k = 0; k < 2; k++) push_exp(3, 8'(8'h30 + k));
    push_exp(0, 8'h04);
    @(posedge clk);
    #1;
    load_src(0, 5, 8'h00);
    load_src(1, 2, 8'h10);
    load_src(2, 2, 8'h20);
    load_src(3, 2, 8'h30);
    wait_quiet("t2_quiet", 400);

    // Burst limit: six bytes from requester 2 go out as 4 + 2 with an IDLE pass between.
    do_reset();
    done_delay = 4;
    for (int k = 0; k < 6; k++) push_exp(2, 8'(8'h60 + k));
    @(posedge clk);
    #1 load_src(2, 6, 8'h60);
    wait_quiet("t3_quiet", 300);
    checkOutput("t3_frames", send_cyc_q.size(), 6);
    if (send_cyc_q.size() == 6)
      for (int k = 1; k < 6; k++)
        checkOutput("t3_send_spacing", send_cyc_q[k] - send_cyc_q[k-1], burst_gaps[k-1]);

    // Streaming requester 1 yields to requester 3 after a full burst, then resumes.
    do_reset();
    done_delay = 3;
    for (int k = 0; k < 4; k++) push_exp(1, 8'(8'h90 + k));
    push_exp(3, 8'hB0);
    push_exp(1, 8'h94);
    push_exp(1, 8'h95);
    @(posedge clk);
    #1;
    load_src(1, 6, 8'h90);
    load_src(3, 1, 8'hB0);
    wait_quiet("t4_quiet", 300);

    // Watchdog: tx_done withheld, error 16 cycles after send, pointer moves past requester 0.
    do_reset();
    done_delay = -1;
    base_to = to_cnt;
    push_exp(0, 8'h77);
    @(posedge clk);
    #1 load_src(0, 1, 8'h77);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t5_timeout_seen", 32'(found), 1);
    checkOutput("t5_timeout_latency", last_to_cyc - last_send_cyc, TIMEOUT);
    checkOutput("t5_timeout_no_ready", req_ready, '0);
    @(negedge clk);
    #1;
    checkOutput("t5_idle_after", {busy, timeout_err}, '0);
    done_delay = 3;
    push_exp(1, 8'h81);
    push_exp(0, 8'h80);
    @(posedge clk);
    #1;
    load_src(0, 1, 8'h80);
    load_src(1, 1, 8'h81);
    wait_quiet("t5_quiet", 200);
    checkOutput("t5_timeout_count", to_cnt - base_to, 1);

    // tx_done on the expiry cycle completes the frame without an error.
    do_reset();
    done_delay = TIMEOUT;
    base_to = to_cnt;
    push_exp(2, 8'h3C);
    @(posedge clk);
    #1 load_src(2, 1, 8'h3C);
    wait_quiet("edge_done_quiet", 100);
    checkOutput("edge_done_no_error", to_cnt - base_to, 0);

    // tx_done one cycle late: watchdog fires and the stray tx_done is ignored.
    do_reset();
    done_delay = TIMEOUT + 1;
    base_to   = to_cnt;
    base_send = send_cnt;
    push_exp(2, 8'h3D);
    @(posedge clk);
    #1 load_src(2, 1, 8'h3D);
    wait_quiet("edge_late_quiet", 100);
    checkOutput("edge_late_error", to_cnt - base_to, 1);
    checkOutput("edge_late_sends", send_cnt - base_send, 1);

    // Asynchronous reset during WAIT; the pending tx_done must not restart anything.
    do_reset();
    done_delay = 10;
    base_send  = send_cnt;
    base_ready = ready_cnt;
    push_exp(0, 8'h5A);
    @(posedge clk);
    #1 load_src(0, 1, 8'h5A);
    wait_send("t6_send_seen", base_send, 20);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", {req_ready, send, data_in, grant_id, busy, timeout_err}, '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_quiet("t6_quiet", 100);
    repeat (5) @(negedge clk);
    checkOutput("t6_sends", send_cnt - base_send, 1);
    checkOutput("t6_readies", ready_cnt - base_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
